// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter that owns one shared WIDTH-bit register.
// Optional SHREG_PARITY_EN adds q_par, the registered even parity of q.
module shared_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [PW-1:0]         owner,
    output logic                  locked
`ifdef SHREG_PARITY_EN
    ,
    output logic                  q_par
`endif
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state;
    state_t           nstate;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_n;
    logic [PW-1:0]    win;
    logic             found;
    logic             wr;
    logic [PW-1:0]    widx;
    logic [WIDTH-1:0] wd [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign wd[g] = wdata[g*WIDTH +: WIDTH];
    end

    assign locked = (state == LOCKED);

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NREQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    // Next state, write enable and the requester whose data is committed.
    always_comb begin
        nstate = state;
        wr     = 1'b0;
        widx   = owner;
        ptr_n  = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    wr    = 1'b1;
                    widx  = win;
                    ptr_n = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                    if (lock[win]) nstate = LOCKED;
                end
            end
            LOCKED: begin
                // The pointer stays put while the owner holds the register.
                if (req[owner]) begin
                    wr   = 1'b1;
                    widx = owner;
                    if (!lock[owner]) nstate = IDLE;
                end else begin
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // State register; reset drops any lock in progress.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Shared register, grant pulse, owner and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
            gnt     <= '0;
            owner   <= '0;
            ptr     <= '0;
        end else begin
            gnt <= '0;
            ptr <= ptr_n;
            if (wr) begin
                q       <= wd[widx];
                gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << widx;
                owner   <= widx;
                q_valid <= 1'b1;
            end
        end
    end

`ifdef SHREG_PARITY_EN
    // Parity tracks q, updated on the same edge from the incoming data.
    always_ff @(posedge clk) begin
        if (rst)     q_par <= 1'b0;
        else if (wr) q_par <= ^wd[widx];
    end
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed, table-driven bench for shared_reg_arbiter (NREQ=4, WIDTH=8).
// Runs with or without SHREG_PARITY_EN.
module tb_shared_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        q_valid;
    logic [1:0]  owner;
    logic        locked;
`ifdef SHREG_PARITY_EN
    logic        q_par;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shared_reg_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner),
        .locked  (locked)
`ifdef SHREG_PARITY_EN
        ,
        .q_par   (q_par)
`endif
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] wd;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic [1:0]  own;
        logic        qv;
        logic        lk;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic [3:0] rq, logic [3:0] lk,
                                logic [31:0] wd, logic [3:0] g, logic [7:0] eq,
                                logic [1:0] ow, logic qv, logic el);
        vec_t v;
        v.rst = r;  v.req = rq; v.lock = lk; v.wd = wd;
        v.gnt = g;  v.q = eq;   v.own = ow;  v.qv = qv; v.lk = el;
        tbl.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(logic r, logic [3:0] rq, logic [3:0] lk, logic [31:0] wd);
        rst = r; req = rq; lock = lk; wdata = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0; wdata = '0;

        // reset with all requesting
        add(1, 4'hF, 4'h0, 32'h44332211, 4'b0000, 8'h00, 0, 0, 0);
        add(1, 4'hF, 4'h0, 32'h44332211, 4'b0000, 8'h00, 0, 0, 0);
        // single request from requester 2
        add(0, 4'b0100, 4'h0, 32'h00A50000, 4'b0100, 8'hA5, 2, 1, 0);
        add(0, 4'b0000, 4'h0, 32'h00000000, 4'b0000, 8'hA5, 2, 1, 0);
        // all requesting, pointer at 3
        add(0, 4'hF, 4'h0, 32'h44332211, 4'b1000, 8'h44, 3, 1, 0);
        add(0, 4'hF, 4'h0, 32'h44332211, 4'b0001, 8'h11, 0, 1, 0);
        add(0, 4'hF, 4'h0, 32'h44332211, 4'b0010, 8'h22, 1, 1, 0);
        add(0, 4'hF, 4'h0, 32'h44332211, 4'b0100, 8'h33, 2, 1, 0);
        add(0, 4'hF, 4'h0, 32'h44332211, 4'b1000, 8'h44, 3, 1, 0);
        add(0, 4'hF, 4'h0, 32'h44332211, 4'b0001, 8'h11, 0, 1, 0);
        add(0, 4'hF, 4'h0, 32'h44332211, 4'b0010, 8'h22, 1, 1, 0);
        add(0, 4'hF, 4'h0, 32'h44332211, 4'b0100, 8'h33, 2, 1, 0);
        add(0, 4'hF, 4'h0, 32'h44332211, 4'b1000, 8'h44, 3, 1, 0);
        // req0 locks for 3 writes, releases on the 4th; req1 waits
        add(0, 4'b0011, 4'b0001, 32'h0000B1A0, 4'b0001, 8'hA0, 0, 1, 1);
        add(0, 4'b0011, 4'b0001, 32'h0000B1A1, 4'b0001, 8'hA1, 0, 1, 1);
        add(0, 4'b0011, 4'b0001, 32'h0000B1A2, 4'b0001, 8'hA2, 0, 1, 1);
        add(0, 4'b0011, 4'b0000, 32'h0000B1A3, 4'b0001, 8'hA3, 0, 1, 0);
        add(0, 4'b0011, 4'b0000, 32'h0000B1A3, 4'b0010, 8'hB1, 1, 1, 0);
        // lock by 2, then idle release while others request
        add(0, 4'b0100, 4'b0100, 32'h00C20000, 4'b0100, 8'hC2, 2, 1, 1);
        add(0, 4'b1001, 4'b0000, 32'hD30000E0, 4'b0000, 8'hC2, 2, 1, 0);
        add(0, 4'b1001, 4'b0000, 32'hD30000E0, 4'b1000, 8'hD3, 3, 1, 0);
        // lock on an ungranted requester is ignored
        add(0, 4'b0011, 4'b0010, 32'h0000F1E0, 4'b0001, 8'hE0, 0, 1, 0);
        // lock by 3, reset mid-burst, then full request grants 0
        add(0, 4'b1000, 4'b1000, 32'hF3000000, 4'b1000, 8'hF3, 3, 1, 1);
        add(0, 4'b1000, 4'b1000, 32'hF4000000, 4'b1000, 8'hF4, 3, 1, 1);
        add(1, 4'b1000, 4'b1000, 32'hF5000000, 4'b0000, 8'h00, 0, 0, 0);
        add(0, 4'hF, 4'h0, 32'h44332211, 4'b0001, 8'h11, 0, 1, 0);
        // single requester held: gnt stays high, one write per cycle
        add(0, 4'b0010, 4'h0, 32'h00005500, 4'b0010, 8'h55, 1, 1, 0);
        add(0, 4'b0010, 4'h0, 32'h00006600, 4'b0010, 8'h66, 1, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].wd);
            check($sformatf("v%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            check($sformatf("v%0d q", i), 32'(q), 32'(tbl[i].q));
            check($sformatf("v%0d q_valid", i), 32'(q_valid), 32'(tbl[i].qv));
            check($sformatf("v%0d locked", i), 32'(locked), 32'(tbl[i].lk));
            if (tbl[i].qv || tbl[i].rst)
                check($sformatf("v%0d owner", i), 32'(owner), 32'(tbl[i].own));
`ifdef SHREG_PARITY_EN
            check($sformatf("v%0d q_par", i), 32'(q_par), 32'(^tbl[i].q));
`endif
        end

        // pointer returns to 0 on reset: advance it to 2, reset, then all request
        step(0, 4'b0010, 4'h0, 32'h00007700);
        check("ptr_adv gnt", 32'(gnt), 32'h2);
        step(1, 4'b0000, 4'h0, 32'h0);
        check("ptr_rst gnt", 32'(gnt), 32'h0);
        step(0, 4'hF, 4'h0, 32'h44332211);
        check("ptr_rst regrant", 32'(gnt), 32'h1);
        check("ptr_rst q", 32'(q), 32'h11);

        // parity of q
        step(0, 4'b0001, 4'h0, 32'h00000007);
        check("par07 q", 32'(q), 32'h07);
`ifdef SHREG_PARITY_EN
        check("par07 q_par", 32'(q_par), 32'h1);
`endif
        step(0, 4'b0001, 4'h0, 32'h00000003);
        check("par03 q", 32'(q), 32'h03);
`ifdef SHREG_PARITY_EN
        check("par03 q_par", 32'(q_par), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
